// File: rtl/pwm_sample_reader.sv
// PWM audio playback engine: fetches 32-bit sample words over Avalon-MM, unpacks two
// signed 16-bit samples per word, scales by volume and drives a PWM pin.
// Optional: define PWM_READER_LOOP_EN to replay the buffer continuously until stop.
module pwm_sample_reader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SAMPLE_DIV = 3125,
    parameter int unsigned PWM_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] startaddr,
    input  logic [31:0] stopaddr,
    input  logic [3:0]  volume,
    input  logic        start,
    input  logic        stop,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        pwm_out,
    output logic        busy,
    output logic        irq
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DW-1:0]       DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [PWM_BITS-1:0] MIDSCALE = PWM_BITS'(1) << (PWM_BITS - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] start_q, start_d;
    logic [31:0] stop_q, stop_d;
    logic        irq_q, irq_d;
    logic        discard_q, discard_d;
    logic        push, flush, clear_play;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   head;
    logic          pop;
    logic          fifo_room;

    logic [DW-1:0]       div_q, div_d;
    logic                tick;
    logic                half_q, half_d;
    logic [15:0]         sample_q, sample_d;
    logic [PWM_BITS-1:0] samp_duty_q, samp_duty_d;
    logic [PWM_BITS-1:0] duty_target;
    logic [PWM_BITS-1:0] pwm_cnt_q, duty_q;

    function automatic logic [PWM_BITS-1:0] scale_duty(input logic [15:0] s,
                                                       input logic [3:0]  vol);
        logic signed [20:0] prod;
        logic signed [20:0] shifted;
        logic [15:0]        sat;
        logic [15:0]        biased;
        prod    = $signed({{5{s[15]}}, s}) * $signed({17'd0, vol});
        shifted = prod >>> 4;
        if (shifted > 21'sd32767) begin
            sat = 16'h7fff;
        end else if (shifted < -21'sd32768) begin
            sat = 16'h8000;
        end else begin
            sat = shifted[15:0];
        end
        biased = sat ^ 16'h8000;
        return PWM_BITS'(biased >> (16 - PWM_BITS));
    endfunction

    assign busy        = (state_q != StIdle);
    assign irq         = irq_q;
    assign avm_address = addr_q;
    assign fifo_room   = (count_q < CW'(FIFO_DEPTH));
    // A discarded read still in flight blocks new requests: one outstanding at most.
    assign avm_read    = (state_q == StReq) && fifo_room && !discard_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        start_d    = start_q;
        stop_d     = stop_q;
        irq_d      = 1'b0;
        discard_d  = discard_q;
        push       = 1'b0;
        flush      = 1'b0;
        clear_play = 1'b0;
        if (discard_q && avm_readdatavalid) begin
            discard_d = 1'b0;
        end
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    start_d    = startaddr;
                    stop_d     = stopaddr;
                    addr_d     = startaddr;
                    flush      = 1'b1;
                    clear_play = 1'b1;
                    if (stopaddr <= startaddr) begin
                        irq_d = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (stop) begin
                    state_d = StIdle;
                    flush   = 1'b1;
                    if (avm_read && !avm_waitrequest) begin
                        discard_d = 1'b1;
                    end
                end else if (avm_read && !avm_waitrequest) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (stop) begin
                    state_d = StIdle;
                    flush   = 1'b1;
                    if (!avm_readdatavalid) begin
                        discard_d = 1'b1;
                    end
                end else if (avm_readdatavalid) begin
                    push = 1'b1;
                    if (addr_q + 32'd4 == stop_q) begin
`ifdef PWM_READER_LOOP_EN
                        addr_d  = start_q;
                        irq_d   = 1'b1;
                        state_d = StReq;
`else
                        addr_d  = addr_q + 32'd4;
                        state_d = StDrain;
`endif
                    end else begin
                        addr_d  = addr_q + 32'd4;
                        state_d = StReq;
                    end
                end
            end
            StDrain: begin
                if (stop) begin
                    state_d = StIdle;
                    flush   = 1'b1;
                end else if (count_q == '0 && !half_q) begin
                    state_d = StIdle;
                    irq_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            start_q   <= '0;
            stop_q    <= '0;
            irq_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            irq_q     <= irq_d;
            discard_q <= discard_d;
        end
    end

    assign head    = fifo_mem[rd_ptr_q];
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= avm_readdata;
        end
    end

    assign tick = busy && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + DW'(1);
        if (!busy || tick) begin
            div_d = '0;
        end
    end

    // Underrun ticks keep the held sample but still rescale it with the live volume.
    always_comb begin
        half_d      = half_q;
        sample_d    = sample_q;
        samp_duty_d = samp_duty_q;
        pop         = 1'b0;
        if (clear_play) begin
            half_d      = 1'b0;
            sample_d    = '0;
            samp_duty_d = MIDSCALE;
        end else if (flush) begin
            half_d = 1'b0;
        end else if (tick) begin
            if (count_q != '0) begin
                sample_d = half_q ? head[31:16] : head[15:0];
                half_d   = ~half_q;
                pop      = half_q;
            end
            samp_duty_d = scale_duty(sample_d, volume);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q       <= '0;
            half_q      <= 1'b0;
            sample_q    <= '0;
            samp_duty_q <= MIDSCALE;
        end else begin
            div_q       <= div_d;
            half_q      <= half_d;
            sample_q    <= sample_d;
            samp_duty_q <= samp_duty_d;
        end
    end

    assign duty_target = busy ? samp_duty_q : MIDSCALE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            if (pwm_cnt_q == '1) begin
                duty_q <= duty_target;
            end
        end
    end

    assign pwm_out = (pwm_cnt_q < duty_q);

endmodule

// File: tb/tb_pwm_sample_reader.sv
// Directed bench for pwm_sample_reader with a small Avalon-MM slave model.
module tb_pwm_sample_reader;

    localparam int unsigned DIV = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] startaddr = '0;
    logic [31:0] stopaddr = '0;
    logic [3:0]  volume = 4'd15;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        pwm_out;
    logic        busy;
    logic        irq;

    int total = 0;
    int bad = 0;

    pwm_sample_reader #(
        .FIFO_DEPTH(4),
        .SAMPLE_DIV(DIV),
        .PWM_BITS  (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .startaddr        (startaddr),
        .stopaddr         (stopaddr),
        .volume           (volume),
        .start            (start),
        .stop             (stop),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .pwm_out          (pwm_out),
        .busy             (busy),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; equals the PWM counter modulo 256.
    int unsigned cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    int irq_cnt = 0;
    always @(negedge clk) if (rst && irq) irq_cnt++;

    int unsigned lat = 0;
    logic [31:0] stall_addr = 32'hffff_ffff;
    int          stall_left = 0;
    int          stall_seen = 0;
    int          stall_breaks = 0;
    int          acc_cnt = 0;
    logic [31:0] acc_addr[$];
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        pend = 1'b0;
    int unsigned pend_left = 0;
    logic [31:0] pend_data = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h7fff_0000;
            32'h104: return 32'h8000_0001;
            default: return 32'h7fff_7fff;
        endcase
    endfunction

    // Slave: decides waitrequest/accept for the coming edge at each falling edge.
    always @(negedge clk) begin
        avm_readdatavalid = 1'b0;
        if (!rst) begin
            pend            = 1'b0;
            avm_waitrequest = 1'b0;
            prev_wait       = 1'b0;
        end else begin
            if (pend) begin
                if (pend_left == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = pend_data;
                    pend              = 1'b0;
                end else begin
                    pend_left--;
                end
            end
            if (prev_wait && !(avm_read && avm_address == prev_addr)) stall_breaks++;
            avm_waitrequest = 1'b0;
            if (avm_read && avm_address == stall_addr && stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
                stall_seen++;
            end
            prev_wait = avm_waitrequest;
            prev_addr = avm_address;
            if (avm_read && !avm_waitrequest) begin
                acc_cnt++;
                acc_addr.push_back(avm_address);
                pend      = 1'b1;
                pend_left = lat;
                pend_data = mem_word(avm_address);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] sa, input logic [31:0] ea,
                               output int unsigned t0);
        startaddr = sa;
        stopaddr  = ea;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // High cycles over one full PWM period starting at counter 0.
    task automatic measure(output int highs);
        while (cyc % 256 != 0) @(negedge clk);
        highs = 0;
        repeat (256) begin
            highs += int'(pwm_out);
            @(negedge clk);
        end
    endtask

    task automatic duty_at(input string tag, input int unsigned t0, input int n,
                           input int exp);
        int h;
        wait_until(t0 + n * DIV + 4);
        measure(h);
        chk(tag, h, exp);
    endtask

    task automatic wait_irq(input string tag, input int unsigned lim, output int unsigned at);
        while (!irq && cyc < lim) @(negedge clk);
        at = cyc;
        chk(tag, irq, 1'b1);
    endtask

    task automatic wait_acc(input string tag, input int target, input int unsigned lim);
        @(negedge clk);
        #1;
        while (acc_cnt < target && cyc < lim) begin
            @(negedge clk);
            #1;
        end
        chk(tag, acc_cnt, target);
    endtask

    initial begin
        int unsigned t0;
        int unsigned at;
        int          base;
        int          ibase;
        int          h;

        #1;
        chk("rst_addr", avm_address, 32'h0);
        chk("rst_read", avm_read, 1'b0);
        chk("rst_pwm", pwm_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_irq", irq, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_until(260);
        measure(h);
        chk("idle_duty", h, 128);

        // Single pass over two words, zero-wait slave
        volume = 4'd15;
        base   = acc_cnt;
        pulse_start(32'h100, 32'h108, t0);
        chk("a_busy", busy, 1'b1);
        duty_at("a_tick1", t0, 1, 128);
        duty_at("a_tick2", t0, 2, 247);
        duty_at("a_tick3", t0, 3, 128);
        wait_irq("a_irq_seen", t0 + 5000, at);
        chk("a_irq_time", at, t0 + 4097);
        chk("a_busy_fall", busy, 1'b0);
        @(negedge clk);
        chk("a_irq_pulse", irq, 1'b0);
        chk("a_irq_count", irq_cnt, 1);
        chk("a_nreads", acc_cnt - base, 2);
        chk("a_read0", acc_addr[base], 32'h100);
        chk("a_read1", acc_addr[base+1], 32'h104);

        // Waitrequest held for 5 cycles on the first read
        base       = acc_cnt;
        ibase      = irq_cnt;
        stall_addr = 32'h104;
        stall_left = 5;
        pulse_start(32'h104, 32'h10c, t0);
        duty_at("b_tick2", t0, 2, 8);
        duty_at("b_tick3", t0, 3, 247);
        chk("b_stall_cycles", stall_seen, 5);
        chk("b_stall_stable", stall_breaks, 0);
        chk("b_nreads", acc_cnt - base, 2);
        chk("b_read0", acc_addr[base], 32'h104);
        chk("b_read1", acc_addr[base+1], 32'h108);
        wait_irq("b_irq_seen", t0 + 5000, at);
        chk("b_irq_time", at, t0 + 4097);
        stall_addr = 32'hffff_ffff;

        // Empty range
        @(negedge clk);
        base  = acc_cnt;
        ibase = irq_cnt;
        pulse_start(32'h200, 32'h200, t0);
        chk("c_irq", irq, 1'b1);
        chk("c_busy", busy, 1'b0);
        @(negedge clk);
        chk("c_irq_pulse", irq, 1'b0);
        repeat (10) @(negedge clk);
        chk("c_nreads", acc_cnt - base, 0);
        chk("c_irq_count", irq_cnt - ibase, 1);

        // Volume changed to 0 mid-playback, then stop in drain
        base  = acc_cnt;
        ibase = irq_cnt;
        pulse_start(32'h400, 32'h408, t0);
        duty_at("e_vol15", t0, 1, 247);
        volume = 4'd0;
        duty_at("e_vol0", t0, 2, 128);
        volume = 4'd15;
        pulse_stop();
        chk("e_stop_busy", busy, 1'b0);
        wait_until(t0 + 5000);
        chk("e_no_irq", irq_cnt - ibase, 0);
        chk("e_nreads", acc_cnt - base, 2);

        // Stop one cycle after an accepted read; its data arrives later and is dropped
        lat   = 3;
        base  = acc_cnt;
        ibase = irq_cnt;
        pulse_start(32'h300, 32'h340, t0);
        duty_at("d_tick1", t0, 1, 247);
        wait_acc("d_fifth_read", base + 5, t0 + 3000);
        @(negedge clk);
        pulse_stop();
        chk("d_busy", busy, 1'b0);
        chk("d_read_low", avm_read, 1'b0);
        wait_until(cyc + 1100);
        chk("d_no_more_reads", acc_cnt - base, 5);
        chk("d_no_irq", irq_cnt - ibase, 0);
        measure(h);
        chk("d_midscale", h, 128);

        // Asynchronous reset while a read is outstanding
        lat  = 20;
        base = acc_cnt;
        pulse_start(32'h500, 32'h510, t0);
        wait_acc("f_first_read", base + 1, t0 + 100);
        @(negedge clk);
        chk("f_pre_busy", busy, 1'b1);
        chk("f_pre_addr", avm_address, 32'h500);
        #2;
        rst = 1'b0;
        #1;
        chk("f_rst_addr", avm_address, 32'h0);
        chk("f_rst_read", avm_read, 1'b0);
        chk("f_rst_busy", busy, 1'b0);
        chk("f_rst_irq", irq, 1'b0);
        chk("f_rst_pwm", pwm_out, 1'b0);
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        lat  = 0;
        base = acc_cnt;
        @(negedge clk);
        pulse_start(32'h600, 32'h608, t0);
        wait_acc("f_restart_read", base + 1, t0 + 100);
        chk("f_restart_addr", acc_addr[base], 32'h600);
        pulse_stop();
        chk("f_stop_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_sample_reader.md
Name: pwm_sample_reader

Overview:
- Playback engine driven by the PWM audio config registers (startaddr, stopaddr, volume, start, stop, irq).
- On start it acts as an Avalon-MM read master and fetches 32-bit words from startaddr up to stopaddr (exclusive) into a small FIFO.
- It unpacks two signed 16-bit samples per word, scales them by volume and drives a PWM audio pin at a fixed sample rate.
- On completion it pulses irq back to the config block.

Parameters:
- FIFO_DEPTH, 4, word FIFO depth (power of 2, >= 2)
- SAMPLE_DIV, 3125, clk cycles per sample tick (50 MHz / 16 kHz)
- PWM_BITS, 8, PWM resolution; one PWM period = 2^PWM_BITS clk cycles

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- startaddr  input  32  first byte address, word aligned
- stopaddr  input  32  end byte address (exclusive), word aligned
- volume  input  4  gain 0..15
- start  input  1  1-cycle pulse: begin playback
- stop  input  1  1-cycle pulse: abort playback
- avm_address  output  32  read address
- avm_read  output  1  read request
- avm_waitrequest  input  1  slave stall
- avm_readdata  input  32  read data
- avm_readdatavalid  input  1  read data valid
- pwm_out  output  1  PWM audio pin
- busy  output  1  playback active
- irq  output  1  1-cycle pulse: playback finished

Behaviour:
- Reset values: avm_address=0, avm_read=0, pwm_out=0, busy=0, irq=0.
- Reset also clears the FIFO, the held sample (=0), the tick divider and the PWM counter.
- Reset mid-transfer drops any outstanding read with no handshake.
- Fetch FSM:
  - IDLE -> start: latch startaddr/stopaddr, addr=startaddr, busy=1, go to REQ.
  - If stopaddr <= startaddr: no reads; irq pulses on the next cycle; return to IDLE.
  - REQ: assert avm_read with avm_address=addr only when FIFO has room counting the outstanding read (count + pending < FIFO_DEPTH).
  - REQ: hold avm_read and avm_address stable while avm_waitrequest=1. Accepted on the first cycle with waitrequest=0, then go to WAIT.
  - WAIT: on avm_readdatavalid, push word, addr += 4. If addr == stopaddr go to DRAIN, else REQ. One read outstanding maximum.
  - DRAIN: when FIFO is empty and both halves of the last word are consumed: irq=1 for exactly 1 cycle, busy=0, go to IDLE.
- Playback:
  - Tick every SAMPLE_DIV clk cycles (divider free-runs while busy, reset to 0 on start).
  - Per tick, emit next sample: word[15:0] first, then word[31:16], then pop.
  - FIFO empty at tick (underrun): hold previous sample, no error.
- Scaling: s (signed 16) * {1'b0,volume} -> signed 21 bit, arithmetic >> 4, saturate to signed 16.
  - Result offset to unsigned (+32768); top PWM_BITS bits = duty.
  - volume=0 gives duty = 2^(PWM_BITS-1) (midscale).
- PWM: free-running PWM_BITS counter; pwm_out = (counter < duty). Duty updates only at counter wrap to 0.
  - duty=0 gives constant 0; full duty is 2^PWM_BITS-1 high of 2^PWM_BITS.
- When not busy, duty = midscale; pwm_out still toggles at 50%.
- stop while busy:
  - Deassert avm_read immediately if not yet accepted; otherwise wait for the pending readdatavalid and discard it.
  - Flush FIFO, busy=0, go to IDLE; no irq.
- start while busy: ignored. start and stop in the same cycle: stop wins.
- volume is sampled live at each tick.

Optional Feature:
- Macro PWM_READER_LOOP_EN.
- Defined: on addr == stopaddr the fetch FSM reloads addr=startaddr and continues in REQ. irq pulses 1 cycle at each wrap; busy stays 1 until stop.
- Undefined: single pass as above.

Test Plan:
- startaddr=0x100, stopaddr=0x108, data 0x7FFF0000, 0x80000001, volume=15, zero-wait slave -> reads at 0x100, 0x104 only. Samples 0x0000, 0x7FFF, 0x0001, 0x8000 scaled by 15/16 in order. One irq pulse after the 4th tick; busy falls the same cycle.
- Slave holds waitrequest=1 for 5 cycles on 0x104 -> avm_address/avm_read stable for all 5 cycles; exactly one read accepted.
- stopaddr=startaddr=0x200 + start -> zero reads, irq high exactly 1 cycle after start, busy back to 0.
- stop asserted 1 cycle after a read is accepted, readdatavalid arrives 3 cycles later -> data discarded, no further reads, no irq, duty returns to midscale.
- volume=0 during playback of 0x7FFF7FFF -> duty=128 (PWM_BITS=8), pwm_out high 128 of 256 cycles.
- rst asserted mid-WAIT -> all outputs to reset values asynchronously. After release and a new start, fetching restarts at the new startaddr.
